// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction sequencer: command/response records,
// sequencer state encoding and rw polarity.
package i2c_pkg;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } i2c_cmd_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] rdata;
        logic       err;
    } i2c_rsp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } seq_state_e;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO without fall-through: a pushed entry appears at rdata
// one cycle later. Push is ignored when full, pop is ignored when empty.
module i2c_sync_fifo
    import i2c_pkg::*;
#(
    parameter int WIDTH = $bits(i2c_cmd_t),
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Queues I2C commands and runs them one at a time on i2c_master_controller,
// returning one in-order response (read byte + timeout flag) per command.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ENABLE_CYCLES = 5,
    parameter int TIMEOUT       = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [6:0]             cmd_addr,
    input  logic                   cmd_rw,
    input  logic [7:0]             cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [6:0]             rsp_addr,
    output logic                   rsp_rw,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic [6:0]             m_address,
    output logic [7:0]             m_data_in,
    output logic                   m_rw,
    output logic                   m_enable,
    input  logic [7:0]             m_data_out,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] cmd_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = $clog2(ENABLE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam logic [EW-1:0] ENABLE_LAST = EW'(ENABLE_CYCLES - 1);

    seq_state_e state;
    seq_state_e state_nxt;
    i2c_cmd_t   cmd_in;
    i2c_cmd_t   cmd_head;
    i2c_rsp_t   rsp_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          set_err;
    logic          rsp_free;
    logic          timer_done;
    logic          active;
    logic [TW-1:0] timer;
    logic [EW-1:0] en_cnt;
    logic          seen_busy;
    logic          err_flag;

    assign cmd_in     = '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign rsp_free   = !rsp_valid || rsp_ready;
    assign timer_done = (timer == TIMER_LAST);
    assign active     = (state == S_ISSUE) || (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign m_enable   = (state == S_ISSUE);
    assign busy       = (state != S_IDLE) || !fifo_empty;

    i2c_sync_fifo #(
        .WIDTH ($bits(i2c_cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (cmd_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (cmd_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // A pending, unconsumed response blocks the next pop so responses
    // can never overtake each other.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        set_err   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty && m_ready && rsp_free) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (timer_done) begin
                    set_err   = 1'b1;
                    state_nxt = S_RESP;
                end else if (en_cnt == ENABLE_LAST) begin
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (timer_done) begin
                    set_err   = 1'b1;
                    state_nxt = S_RESP;
                end else if (seen_busy || !m_ready) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (m_ready) begin
                    state_nxt = S_RESP;
                end else if (timer_done) begin
                    set_err   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_address <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            timer     <= '0;
            en_cnt    <= '0;
            seen_busy <= 1'b0;
            err_flag  <= 1'b0;
        end else if (pop) begin
            m_address <= cmd_head.addr;
            m_data_in <= cmd_head.wdata;
            m_rw      <= cmd_head.rw;
            timer     <= '0;
            en_cnt    <= '0;
            seen_busy <= 1'b0;
            err_flag  <= 1'b0;
        end else if (active) begin
            timer <= timer + TW'(1);
            if (state == S_ISSUE) en_cnt <= en_cnt + EW'(1);
            if (!m_ready && state != S_WAIT_DONE) seen_busy <= 1'b1;
            if (set_err) err_flag <= 1'b1;
        end
    end

    // m_address/m_rw still hold the completing command while in S_RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (state == S_RESP) begin
            rsp_valid   <= 1'b1;
            rsp_q.addr  <= m_address;
            rsp_q.rw    <= m_rw;
            rsp_q.err   <= err_flag;
            rsp_q.rdata <= (m_rw == I2C_RW_READ && !err_flag) ? m_data_out : 8'h00;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end
    end

    assign rsp_addr  = rsp_q.addr;
    assign rsp_rw    = rsp_q.rw;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: behavioural master/slave stub, response and
// issue monitors, and scenario tasks run in sequence.
module tb_i2c_txn_sequencer;
    localparam int DEPTH  = 4;
    localparam int EN_CYC = 5;
    localparam int TMO    = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [6:0] rsp_addr;
    logic       rsp_rw;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [6:0] m_address;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic [7:0] m_data_out;
    logic       m_ready;
    logic       busy;
    logic [$clog2(DEPTH):0] cmd_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_count = 0;

    logic [16:0] exp_q[$];   // {addr, rw, rdata, err}
    logic [15:0] iss_q[$];   // {addr, rw, wdata}
    logic [7:0]  slave_rd[128];
    logic [7:0]  slave_wr[128];

    bit dead = 0;
    bit hold_master = 0;
    int busy_min = 1;
    int busy_max = 8;
    int rsp_mode = 0;        // 0: always ready, 1: never ready, 2: random

    i2c_txn_sequencer #(
        .DEPTH         (DEPTH),
        .ENABLE_CYCLES (EN_CYC),
        .TIMEOUT       (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_rw     (cmd_rw),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_rw     (rsp_rw),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_address  (m_address),
        .m_data_in  (m_data_in),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_data_out (m_data_out),
        .m_ready    (m_ready),
        .busy       (busy),
        .cmd_count  (cmd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Master + slave stub: on an enable rise it goes busy for a while,
    // then returns read data or records the written byte.
    initial begin : master_stub
        logic [6:0] a;
        logic       r;
        logic [7:0] d;
        int         dly;
        int         blen;
        bit         prev;
        bit         abort;
        m_ready    = 1'b1;
        m_data_out = 8'h00;
        prev       = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ready = 1'b1;
                prev    = 1'b0;
            end else if (m_enable && !prev) begin
                a = m_address;
                r = m_rw;
                d = m_data_in;
                abort = 1'b0;
                m_data_out = 8'($urandom);
                if (!dead) begin
                    dly  = $urandom_range(0, 2);
                    blen = $urandom_range(busy_min, busy_max);
                    for (int i = 0; i < dly && !abort; i++) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    if (!abort) m_ready = 1'b0;
                    for (int i = 0; i < blen && !abort; i++) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    if (!abort) begin
                        if (r) m_data_out = slave_rd[a];
                        else   slave_wr[a] = d;
                    end
                    m_ready = 1'b1;
                end
                prev = abort ? 1'b0 : m_enable;
            end else begin
                m_ready = !hold_master;
                prev    = m_enable;
            end
        end
    end

    // Issue monitor: order/content of issued commands, enable width,
    // and m_* stability until the response appears.
    initial begin : issue_mon
        bit          prev;
        bit          in_txn;
        int          width;
        logic [6:0]  a_cap;
        logic        r_cap;
        logic [15:0] e;
        prev = 1'b0;
        in_txn = 1'b0;
        width = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                in_txn = 1'b0;
                width = 0;
            end else begin
                if (in_txn) begin
                    if (rsp_valid) begin
                        in_txn = 1'b0;
                    end else begin
                        checks++;
                        if (m_address !== a_cap || m_rw !== r_cap) begin
                            errors++;
                            $display("FAIL m_stable got addr=%h rw=%b want addr=%h rw=%b", m_address, m_rw, a_cap, r_cap);
                        end
                    end
                end
                if (m_enable && !prev) begin
                    issue_count++;
                    checks++;
                    if (iss_q.size() == 0) begin
                        errors++;
                        $display("FAIL issue_unexpected got addr=%h rw=%b want none", m_address, m_rw);
                    end else begin
                        e = iss_q.pop_front();
                        if (m_address !== e[15:9] || m_rw !== e[8] || (e[8] == 1'b0 && m_data_in !== e[7:0])) begin
                            errors++;
                            $display("FAIL issue got addr=%h rw=%b data=%h want addr=%h rw=%b data=%h",
                                     m_address, m_rw, m_data_in, e[15:9], e[8], e[7:0]);
                        end
                    end
                    a_cap = m_address;
                    r_cap = m_rw;
                    in_txn = 1'b1;
                    width = 0;
                end
                if (m_enable) width++;
                if (!m_enable && prev) begin
                    checks++;
                    if (width != EN_CYC) begin
                        errors++;
                        $display("FAIL enable_width got %0d want %0d", width, EN_CYC);
                    end
                end
                prev = m_enable;
            end
        end
    end

    // Response sink: chooses rsp_ready, checks each consumed response in
    // order and checks stability while stalled.
    initial begin : rsp_sink
        logic [16:0] got;
        logic [16:0] e;
        logic [16:0] held;
        bit          stalled;
        stalled = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (rst) begin
                stalled = 1'b0;
            end else if (rsp_valid) begin
                got = {rsp_addr, rsp_rw, rsp_rdata, rsp_err};
                if (stalled) begin
                    checks++;
                    if (got !== held) begin
                        errors++;
                        $display("FAIL rsp_stable got %h want %h", got, held);
                    end
                end
                if (rsp_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected got %h want none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL rsp got addr=%h rw=%b rdata=%h err=%b want addr=%h rw=%b rdata=%h err=%b",
                                     got[16:10], got[9], got[8:1], got[0], e[16:10], e[9], e[8:1], e[0]);
                        end
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = got;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic push_cmd(input logic [6:0] a, input logic r, input logic [7:0] d);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = r;
        cmd_wdata = d;
        while (!cmd_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept got ready=0 want ready=1 within 3000 cycles");
            cmd_valid = 1'b0;
            return;
        end
        iss_q.push_back({a, r, d});
        exp_q.push_back({a, r, ((r && !dead) ? slave_rd[a] : 8'h00), dead});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || busy || rsp_valid) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0 || busy || rsp_valid) begin
            errors++;
            $display("FAIL drain_%s got pending=%0d busy=%b want pending=0 busy=0", name, exp_q.size(), busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++;
        if (cmd_count !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_count got count=%0d busy=%b want 0 0", cmd_count, busy);
        end
        checks++;
        if (rsp_valid !== 1'b0 || {rsp_addr, rsp_rw, rsp_rdata, rsp_err} !== 17'h0) begin
            errors++; $display("FAIL reset_rsp got valid=%b fields=%h want 0 0", rsp_valid, {rsp_addr, rsp_rw, rsp_rdata, rsp_err});
        end
        checks++;
        if (m_enable !== 1'b0 || {m_address, m_data_in, m_rw} !== 16'h0) begin
            errors++; $display("FAIL reset_master got en=%b fields=%h want 0 0", m_enable, {m_address, m_data_in, m_rw});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        rsp_mode = 0;
        slave_wr[7'h2A] = 8'h00;
        push_cmd(7'h2A, 1'b0, 8'hA5);
        checks++;
        if (m_enable !== 1'b0) begin errors++; $display("FAIL latency_early got en=%b want 0", m_enable); end
        @(negedge clk);
        checks++;
        if (m_enable !== 1'b1) begin errors++; $display("FAIL latency_rise got en=%b want 1", m_enable); end
        drain("write");
        checks++;
        if (slave_wr[7'h2A] !== 8'hA5) begin
            errors++; $display("FAIL write_data got %h want a5", slave_wr[7'h2A]);
        end
    endtask

    task automatic test_read();
        slave_rd[7'h33] = 8'h55;
        push_cmd(7'h33, 1'b1, 8'h00);
        drain("read");
    endtask

    task automatic test_back_to_back();
        slave_rd[7'h2A] = 8'hF0;
        slave_rd[7'h33] = 8'h3C;
        hold_master = 1'b1;
        repeat (2) @(negedge clk);
        push_cmd(7'h2A, 1'b0, 8'h11);
        push_cmd(7'h33, 1'b0, 8'h22);
        push_cmd(7'h2A, 1'b1, 8'h00);
        push_cmd(7'h33, 1'b1, 8'h00);
        checks++;
        if (cmd_count !== 3'(DEPTH) || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL fifo_full got count=%0d ready=%b want %0d 0", cmd_count, cmd_ready, DEPTH);
        end
        hold_master = 1'b0;
        drain("b2b");
    endtask

    task automatic test_timeout();
        int g = 0;
        int t0;
        int t1;
        dead = 1'b1;
        push_cmd(7'h33, 1'b1, 8'h00);
        while (!m_enable && g < 10) begin @(negedge clk); g++; end
        t0 = cyc;
        g = 0;
        while (!rsp_valid && g < 200) begin @(negedge clk); g++; end
        t1 = cyc;
        checks++;
        if (!rsp_valid || (t1 - t0) < TMO || (t1 - t0) > TMO + 4) begin
            errors++; $display("FAIL timeout_latency got %0d cycles valid=%b want %0d..%0d", t1 - t0, rsp_valid, TMO, TMO + 4);
        end
        drain("timeout");
        dead = 1'b0;
        push_cmd(7'h2A, 1'b0, 8'h77);
        drain("after_timeout");
        checks++;
        if (slave_wr[7'h2A] !== 8'h77) begin
            errors++; $display("FAIL after_timeout_write got %h want 77", slave_wr[7'h2A]);
        end
    endtask

    task automatic test_stall();
        int g = 0;
        int ic;
        rsp_mode = 1;
        slave_rd[7'h33] = 8'h6B;
        push_cmd(7'h2A, 1'b0, 8'h31);
        push_cmd(7'h33, 1'b1, 8'h00);
        while (!rsp_valid && g < 200) begin @(negedge clk); g++; end
        ic = issue_count;
        repeat (30) @(negedge clk);
        checks++;
        if (issue_count != ic || cmd_count !== 3'd1 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL stall got issues=%0d count=%0d valid=%b want issues=%0d count=1 valid=1",
                               issue_count, cmd_count, rsp_valid, ic);
        end
        rsp_mode = 0;
        drain("stall");
    endtask

    task automatic test_midreset();
        int g = 0;
        busy_min = 30;
        busy_max = 30;
        slave_rd[7'h33] = 8'h99;
        push_cmd(7'h33, 1'b1, 8'h00);
        push_cmd(7'h2A, 1'b0, 8'h44);
        while (!(busy && !m_enable && !m_ready && cmd_count == 3'd1) && g < 60) begin @(negedge clk); g++; end
        rst = 1'b1;
        exp_q.delete();
        iss_q.delete();
        @(negedge clk);
        checks++;
        if (m_enable !== 1'b0 || rsp_valid !== 1'b0 || cmd_count !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset got en=%b valid=%b count=%0d ready=%b busy=%b want 0 0 0 1 0",
                               m_enable, rsp_valid, cmd_count, cmd_ready, busy);
        end
        rst = 1'b0;
        busy_min = 1;
        busy_max = 8;
        repeat (2) @(negedge clk);
        push_cmd(7'h33, 1'b1, 8'h00);
        drain("midreset");
    endtask

    task automatic test_random();
        rsp_mode = 2;
        for (int i = 0; i < 128; i++) slave_rd[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            push_cmd(7'($urandom), 1'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("random");
        rsp_mode = 0;
    endtask

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog got still running want finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_rw = 1'b0;
        cmd_wdata = '0;
        for (int i = 0; i < 128; i++) begin
            slave_rd[i] = 8'h00;
            slave_wr[i] = 8'h00;
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_stall();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
- Command-queue front end sitting directly upstream of i2c_master_controller. Drives its address/data_in/rw/enable pins and consumes its data_out/ready.
- Accepts I2C transactions (7-bit addr, rw, write byte) over a valid/ready stream and buffers them in a FIFO.
- Issues transactions to the master one at a time and returns one response per transaction: read data plus an error flag.
- Removes hand-timed enable pulses and fixed delays from the system and benches.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
ENABLE_CYCLES, 5, cycles m_enable is held high per issue (>=1)
TIMEOUT, 4096, max cycles waiting for master busy/done before error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  7  target slave address
cmd_rw  in  1  0=write, 1=read
cmd_wdata  in  8  write byte (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_addr  out  7  address of completed command
rsp_rw  out  1  rw of completed command
rsp_rdata  out  8  read byte; 0 for writes or errors
rsp_err  out  1  transaction timed out
m_address  out  7  to master address
m_data_in  out  8  to master data_in
m_rw  out  1  to master rw
m_enable  out  1  to master enable
m_data_out  in  8  from master data_out
m_ready  in  1  from master ready (1 = idle)
busy  out  1  state != IDLE or FIFO non-empty
cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, active-high): FIFO emptied. All outputs 0 except cmd_ready=1. State=IDLE. Counters cleared. Reset mid-transaction abandons the command with no response; the master shares rst.
- Command FIFO:
  - No fall-through.
  - cmd_ready = (cmd_count != DEPTH).
  - Push and pop in the same cycle: count unchanged. When full, push is blocked but pop proceeds.
  - An entry pushed into an empty FIFO is poppable the following cycle.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: pop when FIFO non-empty & m_ready=1 & !(rsp_valid & !rsp_ready). On pop, register m_address/m_data_in/m_rw, clear timers, go ISSUE. m_* hold stable until the next pop.
- ISSUE: m_enable=1 for exactly ENABLE_CYCLES cycles, then WAIT_BUSY. A sticky seen_busy flag sets whenever m_ready=0 during ISSUE or WAIT_BUSY.
- WAIT_BUSY: on seen_busy, go WAIT_DONE.
- WAIT_DONE: when m_ready=1, go RESP.
- Timeout: a single counter runs through ISSUE/WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT, go RESP with err=1.
- RESP (one cycle):
  - Load rsp_addr/rsp_rw/rsp_err.
  - rsp_rdata = m_data_out if rw=1 & !err, else 0.
  - Set rsp_valid, go IDLE.
- rsp_valid holds, with fields stable, until the rsp_ready handshake. rsp_ready with rsp_valid=0 has no effect. The response register clears on handshake; a new response may load in the same cycle.
- Latency: earliest m_enable rise is 2 cycles after cmd acceptance into an empty FIFO.
- Ordering: responses are strictly in command order.

Decomposition:
- Package i2c_pkg:
  - i2c_cmd_t packed struct {addr[6:0], rw, wdata[7:0]}
  - i2c_rsp_t packed struct {addr, rw, rdata, err}
  - seq_state_e enum
  - I2C_RW_WRITE / I2C_RW_READ constants
- One sub-module: i2c_sync_fifo. Parameterised WIDTH=$bits(i2c_cmd_t) and DEPTH, async active-high reset, provides count/full/empty. Instantiated once for the command queue.

Test Plan:
- Write 0x2A/0xA5 pushed to idle sequencer with master and slaves 0x2A/0x33 attached -> m_enable high 5 cycles, slave0 data_received=0xA5, one response {0x2A, rw=0, rdata=0x00, err=0}.
- Read 0x33 with slave1 data_to_send=0x55 -> response rdata=0x55, err=0; m_address=0x33 stable throughout.
- Four back-to-back commands (W 0x2A/0x11, W 0x33/0x22, R 0x2A←0xF0, R 0x33←0x3C) pushed in consecutive cycles -> cmd_ready low at count=4, responses in order with rdata 0x00, 0x00, 0xF0, 0x3C.
- m_ready stub held at 1 (master never busy), TIMEOUT=64 -> response err=1, rdata=0 after 64 cycles; next command still issues.
- rsp_ready held low after first response with 2 commands queued -> no second pop until handshake; rsp fields stable throughout stall.
- rst asserted during WAIT_DONE of a read -> next cycle: m_enable=0, rsp_valid=0, cmd_count=0, cmd_ready=1; a fresh command after release completes normally.
